interval_timer: RTL and testbench
=================================

Name: interval_timer

Overview:
- Timer stage directly downstream of the time-parameter block.
- The controller FSM pulses Start_Timer; this block captures the 4-bit interval length in seconds on `value` from the time-parameter block, then counts it down on an internal 1 Hz enable.
- Produces a single-cycle `expired` pulse back to the FSM.
- Also exports the 1 Hz enable and the remaining seconds, for the walk-light blink and for debug.

Parameters:
- CYCLES_PER_SEC, default 50000000: clk cycles per one-second tick. Benches override to 4.
- TIME_W, default 4: width of the seconds value. Must match the time-parameter output.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start_Timer  in  1  single-cycle request from the FSM to (re)start timing.
- value  in  TIME_W  interval length in seconds; sampled only in a cycle where Start_Timer=1.
- expired  out  1  one-cycle pulse when the interval completes.
- busy  out  1  high while counting.
- remaining  out  TIME_W  seconds left in the current interval; 0 when idle.
- oneHz_enable  out  1  one-cycle pulse every CYCLES_PER_SEC cycles.

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - prescaler=0, state=IDLE, remaining=0, expired=0, busy=0, oneHz_enable=0.
  - A reset mid-interval aborts it; no expired pulse follows the release of reset.
- Prescaler:
  - Counts 0..CYCLES_PER_SEC-1 and wraps.
  - oneHz_enable is registered: high for exactly one cycle per wrap.
  - Start_Timer=1 clears the prescaler to 0 on that edge, so the first second is full length.
- State machine, states IDLE, COUNT, DONE:
  - IDLE: Start_Timer=1 with value!=0 -> COUNT; remaining<=value; busy<=1.
  - IDLE: Start_Timer=1 with value==0 -> DONE; expired<=1 on the next edge.
  - COUNT: each oneHz_enable decrements remaining. A tick with remaining==1 -> DONE, remaining<=0, busy<=0, expired<=1.
  - DONE: lasts one cycle; expired=1 in it; unconditionally -> IDLE, expired<=0.
- Timing:
  - If Start is sampled at edge t, expired is high in the cycle after edge t+value*CYCLES_PER_SEC.
  - For value==0, expired is high in the cycle after edge t+1.
- Restart: Start_Timer=1 in COUNT or DONE reloads from the new value and clears the prescaler. The old interval never produces expired.
- Simultaneous events: Start_Timer=1 on the same edge as the final tick -> Start wins; expired stays 0 and timing restarts.
- value changes while counting are ignored. Only the value present with Start_Timer is used.
- remaining never wraps below 0. A tick in IDLE or DONE has no effect on the state.
- Width: remaining is TIME_W bits unsigned; the maximum interval is 15 s.

Decomposition:
- Shared package holds:
  - state encodings IDLE=2'd0, COUNT=2'd1, DONE=2'd2;
  - TIME_W;
  - interval-select codes shared with the FSM and time-parameter block (base=2'b00, ext=2'b01, yel=2'b10).
- One sub-module: one_hz_divider.
  - Ports: clk, Reset_n, clear, oneHz_enable.
  - Parameter: CYCLES_PER_SEC.
  - The timer FSM and remaining counter stay in interval_timer.

Test Plan (CYCLES_PER_SEC=4):
- Reset: hold Reset_n=0 for 3 cycles with Start_Timer toggling -> all outputs 0; after release, no expired pulse.
- Basic: value=6, Start pulse at edge t.
  - busy=1 from t+1.
  - remaining steps 6,5,...,1 at edges t+4, t+8, ..., t+20.
  - expired=1 for exactly one cycle after edge t+24.
  - busy=0 after edge t+24.
- Restart: value=10, Start at t; then value=3, Start at t+9 -> expired only after edge t+21; none near t+40.
- Zero and coincidence:
  - value=0, Start at t -> expired one cycle after edge t+1; busy never 1.
  - Separately, with value=2, Start at t and again at t+8 -> no expired at t+8; expired after t+16.
- Abort and value change:
  - Start with value=5; pull Reset_n low at t+7 -> outputs 0 immediately, asynchronously, without a clk edge.
  - Separately, value changed to 15 after Start with value=4 -> expired at t+16.

Source files
------------

// File: rtl/interval_timer_pkg.sv
// Shared definitions for the interval timer and its neighbours
// (controller FSM, time-parameter block).
package interval_timer_pkg;

  localparam int TIME_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } timer_state_t;

  // Interval-select codes driven by the FSM into the time-parameter block
  typedef enum logic [1:0] {
    SEL_BASE = 2'b00,
    SEL_EXT  = 2'b01,
    SEL_YEL  = 2'b10
  } interval_sel_t;

endpackage

// File: rtl/interval_timer_if.sv
// Request/status bundle between the controller FSM (master) and the
// interval timer (slave).
interface interval_timer_if #(
  parameter int TIME_W = interval_timer_pkg::TIME_W
) ();
  logic              Start_Timer;
  logic [TIME_W-1:0] value;
  logic              expired;
  logic              busy;
  logic [TIME_W-1:0] remaining;
  logic              oneHz_enable;

  modport master (
    output Start_Timer,
    output value,
    input  expired,
    input  busy,
    input  remaining,
    input  oneHz_enable
  );

  modport slave (
    input  Start_Timer,
    input  value,
    output expired,
    output busy,
    output remaining,
    output oneHz_enable
  );
endinterface

// File: rtl/interval_timer_one_hz_divider.sv
// Prescaler producing a registered one-cycle enable per CYCLES_PER_SEC
// clocks; the enable is high in the cycle whose closing edge wraps the count.
module one_hz_divider #(
  parameter int CYCLES_PER_SEC = 50000000
) (
  input  logic clk,
  input  logic Reset_n,
  input  logic clear,
  output logic oneHz_enable
);

  localparam int PW = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
  localparam logic [PW-1:0] LAST = PW'(CYCLES_PER_SEC - 1);

  logic [PW-1:0] pre_r;
  logic [PW-1:0] pre_s;
  logic          en_r;

  // Next prescaler value: clear restarts a full-length second
  always_comb begin
    pre_s = pre_r;
    if (clear) begin
      pre_s = {PW{1'b0}};
    end else if (pre_r == LAST) begin
      pre_s = {PW{1'b0}};
    end else begin
      pre_s = pre_r + PW'(1);
    end
  end

  // Prescaler and enable registers; enable looks ahead so it lines up with the wrap
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pre_r <= {PW{1'b0}};
      en_r  <= 1'b0;
    end else begin
      pre_r <= pre_s;
      en_r  <= (pre_s == LAST);
    end
  end

  assign oneHz_enable = en_r;

endmodule

// File: rtl/interval_timer.sv
// Interval timer: captures a seconds value on Start_Timer, counts it down on
// the 1 Hz enable and pulses expired once when the interval completes.
module interval_timer #(
  parameter int CYCLES_PER_SEC = 50000000,
  parameter int TIME_W         = interval_timer_pkg::TIME_W
) (
  input logic             clk,
  input logic             Reset_n,
  interval_timer_if.slave bus
);
  import interval_timer_pkg::*;

  timer_state_t      state_r;
  timer_state_t      state_s;
  logic [TIME_W-1:0] rem_r;
  logic [TIME_W-1:0] rem_s;
  logic              busy_r;
  logic              busy_s;
  logic              expired_r;
  logic              expired_s;
  logic              tick_s;

  one_hz_divider #(
    .CYCLES_PER_SEC(CYCLES_PER_SEC)
  ) u_div (
    .clk         (clk),
    .Reset_n     (Reset_n),
    .clear       (bus.Start_Timer),
    .oneHz_enable(tick_s)
  );

  // Next-state logic; Start always wins over any tick or pending completion
  always_comb begin
    state_s   = state_r;
    rem_s     = rem_r;
    busy_s    = busy_r;
    expired_s = 1'b0;
    if (bus.Start_Timer) begin
      if (bus.value != {TIME_W{1'b0}}) begin
        state_s = COUNT;
        rem_s   = bus.value;
        busy_s  = 1'b1;
      end else begin
        state_s = DONE;
        rem_s   = {TIME_W{1'b0}};
        busy_s  = 1'b0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          rem_s  = {TIME_W{1'b0}};
          busy_s = 1'b0;
        end
        COUNT: begin
          if (tick_s) begin
            if (rem_r == TIME_W'(1)) begin
              state_s   = DONE;
              rem_s     = {TIME_W{1'b0}};
              busy_s    = 1'b0;
              expired_s = 1'b1;
            end else begin
              rem_s = rem_r - TIME_W'(1);
            end
          end else begin
            rem_s = rem_r;
          end
        end
        // A zero-length start enters DONE without a pulse and emits it on exit
        DONE: begin
          state_s   = IDLE;
          expired_s = ~expired_r;
        end
        default: begin
          state_s = IDLE;
          rem_s   = {TIME_W{1'b0}};
          busy_s  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r   <= IDLE;
      rem_r     <= {TIME_W{1'b0}};
      busy_r    <= 1'b0;
      expired_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      rem_r     <= rem_s;
      busy_r    <= busy_s;
      expired_r <= expired_s;
    end
  end

  assign bus.expired      = expired_r;
  assign bus.busy         = busy_r;
  assign bus.remaining    = rem_r;
  assign bus.oneHz_enable = tick_s;

endmodule

// File: tb/tb_interval_timer.sv
// Directed self-checking bench for interval_timer with CYCLES_PER_SEC=4.
module tb_interval_timer;

  logic clk = 1'b0;
  logic Reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  interval_timer_if #(.TIME_W(4)) bus ();

  interval_timer #(
    .CYCLES_PER_SEC(4),
    .TIME_W        (4)
  ) dut (
    .clk    (clk),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start sampled on the next edge (edge t); returns just after edge t
  task automatic start_pulse(input int v);
    bus.value       = 4'(v);
    bus.Start_Timer = 1'b1;
    step();
    bus.Start_Timer = 1'b0;
  endtask

  // Run n cycles, report expired pulse count, first offset and whether busy was seen
  task automatic watch(input int n, output int cnt, output int first, output int busy_seen);
    cnt = 0; first = -1; busy_seen = 0;
    for (int k = 1; k <= n; k++) begin
      step();
      if (bus.expired) begin
        cnt++;
        if (first < 0) first = k;
      end
      if (bus.busy) busy_seen = 1;
    end
  endtask

  int cnt, first, bsy;

  initial begin
    bus.Start_Timer = 1'b0;
    bus.value       = 4'd0;

    // Reset held with Start toggling
    for (int i = 0; i < 3; i++) begin
      bus.Start_Timer = ~bus.Start_Timer;
      bus.value       = 4'd7;
      step();
    end
    check("rst_expired", int'(bus.expired), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_remaining", int'(bus.remaining), 0);
    check("rst_onehz", int'(bus.oneHz_enable), 0);
    bus.Start_Timer = 1'b0;
    Reset_n = 1'b1;
    watch(12, cnt, first, bsy);
    check("rst_release_no_exp", cnt, 0);
    check("rst_release_no_busy", bsy, 0);

    // Basic: value 6, expired one cycle after edge t+24
    start_pulse(6);
    check("basic_rem_t", int'(bus.remaining), 6);
    for (int k = 1; k <= 26; k++) begin
      step();
      check($sformatf("basic_rem_%0d", k), int'(bus.remaining), (k < 24) ? 6 - k / 4 : 0);
      check($sformatf("basic_exp_%0d", k), int'(bus.expired), (k == 24) ? 1 : 0);
      check($sformatf("basic_busy_%0d", k), int'(bus.busy), (k < 24) ? 1 : 0);
      if (k == 3 || k == 4) check($sformatf("basic_onehz_%0d", k), int'(bus.oneHz_enable), (k == 3) ? 1 : 0);
    end
    watch(4, cnt, first, bsy);

    // Restart: 10 at t, 3 at t+9 -> expired after edge t+21 only
    start_pulse(10);
    watch(8, cnt, first, bsy);
    check("restart_none_early", cnt, 0);
    start_pulse(3);
    watch(40, cnt, first, bsy);
    check("restart_count", cnt, 1);
    check("restart_offset", first, 12);

    // Zero value: expired after edge t+1, busy never asserted
    start_pulse(0);
    check("zero_busy_t", int'(bus.busy), 0);
    check("zero_exp_t", int'(bus.expired), 0);
    watch(6, cnt, first, bsy);
    check("zero_count", cnt, 1);
    check("zero_offset", first, 1);
    check("zero_busy", bsy, 0);

    // Coincidence: restart on the final tick edge wins
    start_pulse(2);
    watch(7, cnt, first, bsy);
    check("coin_none_early", cnt, 0);
    start_pulse(2);
    watch(12, cnt, first, bsy);
    check("coin_count", cnt, 1);
    check("coin_offset", first, 8);

    // Value change while counting is ignored
    start_pulse(4);
    bus.value = 4'd15;
    watch(24, cnt, first, bsy);
    check("vchg_count", cnt, 1);
    check("vchg_offset", first, 16);

    // Asynchronous abort mid-interval
    start_pulse(5);
    watch(6, cnt, first, bsy);
    check("abort_pre_busy", int'(bus.busy), 1);
    check("abort_pre_rem", int'(bus.remaining), 4);
    #2;
    Reset_n = 1'b0;
    #1;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_rem", int'(bus.remaining), 0);
    check("abort_exp", int'(bus.expired), 0);
    check("abort_onehz", int'(bus.oneHz_enable), 0);
    step();
    step();
    Reset_n = 1'b1;
    watch(30, cnt, first, bsy);
    check("abort_no_exp", cnt, 0);
    check("abort_no_busy", bsy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
